// File: rtl/conv_ddr_pkg.sv
// Shared defaults and FSM encoding for the conv DDR read requester.
package conv_ddr_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 512;
  localparam int BEAT_BYTES = 64;
  localparam int LEN_W      = 16;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/conv_ddr_rd_fifo.sv
// Synchronous show-ahead FIFO buffering returned DDR beats for the conv datapath.
module conv_ddr_rd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == DEPTH_L);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/conv_ddr_rd_requester.sv
// Burst read initiator for the conv DDR port: credit-limited beat issue, response
// buffering, and a valid/ready output stream towards the conv datapath.
module conv_ddr_rd_requester #(
  parameter int ADDR_W     = conv_ddr_pkg::ADDR_W,
  parameter int DATA_W     = conv_ddr_pkg::DATA_W,
  parameter int BEAT_BYTES = conv_ddr_pkg::BEAT_BYTES,
  parameter int LEN_W      = conv_ddr_pkg::LEN_W,
  parameter int FIFO_DEPTH = conv_ddr_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              ddr_rd,
  output logic [ADDR_W-1:0] ddr_rd_adr,
  input  logic [DATA_W-1:0] ddr_data,
  input  logic              valid_ddr_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err_unexpected,
  output logic [1:0]        dbg_state
);

  import conv_ddr_pkg::*;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are
  // both high; valid never waits on ready, and the payload is held while valid
  // is high without ready. This applies to cmd_* and out_*.

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]       DEPTH_L  = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BEAT_INC = ADDR_W'(BEAT_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  received;
  logic [LEN_W-1:0]  issued_inc;
  logic [LEN_W-1:0]  received_inc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              credit_ok;
  logic              issue_now;
  logic              accept_data;
  logic              stray_data;
  logic              final_push;
  logic              cmd_fire;
  logic              fifo_full;
  logic              fifo_empty;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Beats already requested count against FIFO space, so a response always
  // finds a free slot even if the consumer stalls indefinitely.
  assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok    = (credit_used < DEPTH_L);
  assign issue_now    = (state == ST_ISSUE) && credit_ok;
  assign issued_inc   = issued + LEN_W'(1);
  assign received_inc = received + LEN_W'(1);

  assign accept_data = valid_ddr_data && (outstanding != '0);
  assign stray_data  = valid_ddr_data && (outstanding == '0);
  assign final_push  = accept_data && (state == ST_DRAIN) && (received_inc == len_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cur_addr       <= '0;
      len_r          <= '0;
      issued         <= '0;
      received       <= '0;
      outstanding    <= '0;
      ddr_rd         <= 1'b0;
      ddr_rd_adr     <= '0;
      done           <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      ddr_rd <= issue_now;
      done   <= 1'b0;

      if (issue_now) begin
        ddr_rd_adr <= cur_addr;
        cur_addr   <= cur_addr + BEAT_INC;
        issued     <= issued_inc;
      end

      if (accept_data) received <= received_inc;
      if (stray_data)  err_unexpected <= 1'b1;

      case ({issue_now, accept_data})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (cmd_len != '0) begin
              cur_addr <= cmd_addr;
              len_r    <= cmd_len;
              issued   <= '0;
              received <= '0;
              state    <= ST_ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (issue_now && (issued_inc == len_r)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (final_push) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  conv_ddr_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept_data),
    .push_data (ddr_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_conv_ddr_rd_requester.sv
// Directed bench for conv_ddr_rd_requester: 1-cycle DDR responder, address and
// data scoreboards, credit bound, and hand-computed burst expectations.
module tb_conv_ddr_rd_requester;

  localparam int AW    = 32;
  localparam int DW    = 512;
  localparam int LW    = 16;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          ddr_rd;
  logic [AW-1:0] ddr_rd_adr;
  logic [DW-1:0] ddr_data;
  logic          valid_ddr_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err_unexpected;
  logic [1:0]    dbg_state;

  conv_ddr_rd_requester #(
    .ADDR_W(AW), .DATA_W(DW), .BEAT_BYTES(64), .LEN_W(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .ddr_rd         (ddr_rd),
    .ddr_rd_adr     (ddr_rd_adr),
    .ddr_data       (ddr_data),
    .valid_ddr_data (valid_ddr_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done),
    .err_unexpected (err_unexpected),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_adr_q[$];
  logic [AW-1:0] adr_log[$];
  int            rd_cyc_q[$];
  int            rd_count    = 0;
  int            done_cnt    = 0;
  int            pop_cnt     = 0;
  int            credit_used = 0;
  bit            busy_seen   = 0;
  bit            err_allowed = 0;
  bit            mon_en      = 0;

  // responder state
  int            pend_cnt = 0;
  bit            resp_en  = 0;
  bit            inj      = 0;
  int            seq      = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not allowed or bound expired", name);
  endtask

  // ---------------- DDR responder: one beat per request, 1-cycle latency ----------------
  always @(negedge clk) begin
    valid_ddr_data = 1'b0;
    if (resp_en && pend_cnt > 0) begin
      seq++;
      ddr_data = '0;
      ddr_data[31:0]      = 32'hA500_0000 + seq;
      ddr_data[DW-1 -: 32] = seq;
      valid_ddr_data = 1'b1;
      pend_cnt--;
      exp_q.push_back(ddr_data);
    end else if (inj) begin
      ddr_data = {DW{1'b1}};
      valid_ddr_data = 1'b1;
      inj = 0;
    end
    if (ddr_rd === 1'b1) pend_cnt++;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (ddr_rd === 1'b1) begin
        rd_count++;
        credit_used++;
        adr_log.push_back(ddr_rd_adr);
        rd_cyc_q.push_back(cyc);
        if (exp_adr_q.size() == 0) fail_now("ddr_rd_without_command");
        else check("ddr_rd_adr", ddr_rd_adr, exp_adr_q.pop_front());
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        pop_cnt++;
        credit_used--;
        if (exp_q.size() == 0) fail_now("out_beat_without_request");
        else check("out_data", out_data, exp_q.pop_front());
      end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_seen = 1;
      check("credit_bound", (credit_used <= DEPTH), 1);
      if (!err_allowed) check("err_unexpected_low", err_unexpected, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_adr_q.delete();
    pend_cnt    = 0;
    credit_used = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    clear_model();
    reset = 1'b0;
  endtask

  task automatic send_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    logic [AW-1:0] a;
    int k;
    a = addr;
    for (int i = 0; i < int'(len); i++) begin
      exp_adr_q.push_back(a);
      a = a + 32'd64;
    end
    rd_count = 0; done_cnt = 0; pop_cnt = 0; busy_seen = 0;
    adr_log.delete();
    rd_cyc_q.delete();
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    if (k >= 50) fail_now("cmd_accept_timeout");
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt < 1 && k < budget) begin
      tick(1);
      k++;
    end
    if (done_cnt < 1) fail_now("done_timeout");
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && k < budget) begin
      tick(1);
      k++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    out_ready = 1'b0; ddr_data = '0; valid_ddr_data = 1'b0;
    do_reset();
    mon_en = 1;

    check("rst_ddr_rd",     ddr_rd, 0);
    check("rst_ddr_rd_adr", ddr_rd_adr, 0);
    check("rst_out_valid",  out_valid, 0);
    check("rst_done",       done, 0);
    check("rst_busy",       busy, 0);
    check("rst_err",        err_unexpected, 0);
    check("rst_cmd_ready",  cmd_ready, 1);

    // 1: four-beat burst, free-flowing consumer
    resp_en = 1; out_ready = 1'b1;
    send_cmd(32'h0000_1000, 16'd4);
    wait_done(100);
    wait_drain(100);
    tick(3);
    check("t1_rd_count",      rd_count, 4);
    check("t1_back_to_back",  rd_cyc_q[3] - rd_cyc_q[0], 3);
    check("t1_first_adr",     adr_log[0], 32'h0000_1000);
    check("t1_last_adr",      adr_log[3], 32'h0000_10C0);
    check("t1_pops",          pop_cnt, 4);
    check("t1_done_once",     done_cnt, 1);
    check("t1_busy_seen",     busy_seen, 1);
    check("t1_busy_end",      busy, 0);

    // 2: stalled consumer caps issue at the buffer depth
    out_ready = 1'b0;
    send_cmd(32'h0000_2000, 16'd20);
    tick(30);
    check("t2_stall_rd_count", rd_count, 8);
    check("t2_stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_done(200);
    wait_drain(100);
    check("t2_rd_count", rd_count, 20);
    check("t2_pops",     pop_cnt, 20);
    check("t2_err",      err_unexpected, 0);

    // 3: empty burst
    send_cmd(32'h0000_5000, 16'd0);
    check("t3_done_pulse", done, 1);
    check("t3_busy",       busy, 0);
    tick(1);
    check("t3_done_low",   done, 0);
    tick(5);
    check("t3_rd_count",   rd_count, 0);
    check("t3_done_once",  done_cnt, 1);
    check("t3_out_valid",  out_valid, 0);

    // 4: address wraps modulo 2^32
    send_cmd(32'hFFFF_FFC0, 16'd2);
    wait_done(100);
    wait_drain(100);
    check("t4_rd_count", rd_count, 2);
    check("t4_adr0",     adr_log[0], 32'hFFFF_FFC0);
    check("t4_adr1",     adr_log[1], 32'h0000_0000);

    // 5: reset after three issues, then a late response
    resp_en = 0;
    send_cmd(32'h0000_3000, 16'd8);
    tick(3);
    reset = 1'b1;
    tick(1);
    clear_model();
    check("t5_rd_before_reset", rd_count, 3);
    check("t5_ddr_rd",          ddr_rd, 0);
    check("t5_out_valid",       out_valid, 0);
    check("t5_busy",            busy, 0);
    check("t5_cmd_ready",       cmd_ready, 1);
    reset = 1'b0;
    err_allowed = 1;
    inj = 1;
    tick(3);
    check("t5_err_set",   err_unexpected, 1);
    check("t5_out_valid_after_late", out_valid, 0);

    // 6: stray response in IDLE, then a normal burst
    do_reset();
    check("t6_err_cleared", err_unexpected, 0);
    inj = 1;
    tick(3);
    check("t6_err_set",     err_unexpected, 1);
    check("t6_out_valid",   out_valid, 0);
    resp_en = 1;
    send_cmd(32'h0000_4000, 16'd3);
    wait_done(100);
    wait_drain(100);
    check("t6_rd_count",    rd_count, 3);
    check("t6_pops",        pop_cnt, 3);
    check("t6_err_sticky",  err_unexpected, 1);
    check("t6_adr_model_empty", exp_adr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
